// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: round-robin arbiter sharing one memory read port between
// instruction fetch (F) and the load unit (L). One transaction in flight at a
// time, registered outputs, optional ack timeout that aborts with an error.
module mem_rd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  // fetch port
  input  logic [31:0] f_rd_addr,
  input  logic        f_rd_addr_valid,
  output logic [31:0] f_rd_data,
  output logic        f_rd_ack,
  output logic        f_rd_err,
  // load port
  input  logic [31:0] l_rd_addr,
  input  logic        l_rd_addr_valid,
  output logic [31:0] l_rd_data,
  output logic        l_rd_ack,
  output logic        l_rd_err,
  // memory port
  output logic [31:0] mem_rd_addr,
  output logic        mem_rd_addr_valid,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_ack,
  // status
  output logic        busy,
  output logic        grant_l
);

  // A zero timeout still needs a legal (1-bit) counter; it is simply never compared.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;  // 1 = L served last
  logic          grant_l_q, grant_l_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic          mem_valid_q, mem_valid_d;
  logic [31:0]   f_data_q, f_data_d;
  logic [31:0]   l_data_q, l_data_d;
  logic          f_ack_q, f_ack_d;
  logic          l_ack_q, l_ack_d;
  logic          f_err_q, f_err_d;
  logic          l_err_q, l_err_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pick_l;

  // L wins when it is the only requester, or on a tie when F was served last.
  assign pick_l = l_rd_addr_valid && (!f_rd_addr_valid || !last_grant_q);

  // Next-state and next-output computation for the IDLE -> WAIT -> RESP cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_l_d    = grant_l_q;
    mem_addr_d   = mem_addr_q;
    mem_valid_d  = mem_valid_q;
    f_data_d     = f_data_q;
    l_data_d     = l_data_q;
    f_ack_d      = 1'b0;
    l_ack_d      = 1'b0;
    f_err_d      = 1'b0;
    l_err_d      = 1'b0;
    busy_d       = busy_q;
    cnt_d        = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (f_rd_addr_valid || l_rd_addr_valid) begin
          mem_addr_d   = pick_l ? l_rd_addr : f_rd_addr;
          mem_valid_d  = 1'b1;
          last_grant_d = pick_l;
          grant_l_d    = pick_l;
          cnt_d        = '0;
          busy_d       = 1'b1;
          state_d      = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (mem_rd_ack) begin
          // A real ack takes priority even in the cycle the timeout would fire.
          if (grant_l_q) begin
            l_data_d = mem_rd_data;
            l_ack_d  = 1'b1;
          end else begin
            f_data_d = mem_rd_data;
            f_ack_d  = 1'b1;
          end
          mem_valid_d = 1'b0;
          state_d     = ST_RESP;
        end else if (TO_EN && (cnt_q == TO_MAX)) begin
          // Abort: winner gets zero data flagged with an error.
          if (grant_l_q) begin
            l_data_d = 32'h0;
            l_ack_d  = 1'b1;
            l_err_d  = 1'b1;
          end else begin
            f_data_d = 32'h0;
            f_ack_d  = 1'b1;
            f_err_d  = 1'b1;
          end
          mem_valid_d = 1'b0;
          state_d     = ST_RESP;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        mem_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_l_q    <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_valid_q  <= 1'b0;
      f_data_q     <= 32'h0;
      l_data_q     <= 32'h0;
      f_ack_q      <= 1'b0;
      l_ack_q      <= 1'b0;
      f_err_q      <= 1'b0;
      l_err_q      <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_l_q    <= grant_l_d;
      mem_addr_q   <= mem_addr_d;
      mem_valid_q  <= mem_valid_d;
      f_data_q     <= f_data_d;
      l_data_q     <= l_data_d;
      f_ack_q      <= f_ack_d;
      l_ack_q      <= l_ack_d;
      f_err_q      <= f_err_d;
      l_err_q      <= l_err_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign f_rd_data         = f_data_q;
  assign f_rd_ack          = f_ack_q;
  assign f_rd_err          = f_err_q;
  assign l_rd_data         = l_data_q;
  assign l_rd_ack          = l_ack_q;
  assign l_rd_err          = l_err_q;
  assign mem_rd_addr       = mem_addr_q;
  assign mem_rd_addr_valid = mem_valid_q;
  assign busy              = busy_q;
  assign grant_l           = grant_l_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter (TIMEOUT_CYCLES = 4). Inputs change and
// outputs are checked on the falling clock edge.
module tb_mem_rd_arbiter;

  logic        clk;
  logic        reset_n;
  logic [31:0] f_rd_addr;
  logic        f_rd_addr_valid;
  logic [31:0] f_rd_data;
  logic        f_rd_ack;
  logic        f_rd_err;
  logic [31:0] l_rd_addr;
  logic        l_rd_addr_valid;
  logic [31:0] l_rd_data;
  logic        l_rd_ack;
  logic        l_rd_err;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_addr_valid;
  logic [31:0] mem_rd_data;
  logic        mem_rd_ack;
  logic        busy;
  logic        grant_l;

  int errors = 0;
  int checks = 0;

  mem_rd_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .f_rd_addr         (f_rd_addr),
    .f_rd_addr_valid   (f_rd_addr_valid),
    .f_rd_data         (f_rd_data),
    .f_rd_ack          (f_rd_ack),
    .f_rd_err          (f_rd_err),
    .l_rd_addr         (l_rd_addr),
    .l_rd_addr_valid   (l_rd_addr_valid),
    .l_rd_data         (l_rd_data),
    .l_rd_ack          (l_rd_ack),
    .l_rd_err          (l_rd_err),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_addr_valid (mem_rd_addr_valid),
    .mem_rd_data       (mem_rd_data),
    .mem_rd_ack        (mem_rd_ack),
    .busy              (busy),
    .grant_l           (grant_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_addr"},  mem_rd_addr, 32'h0);
    chk({tag, ".mem_valid"}, {31'h0, mem_rd_addr_valid}, 32'h0);
    chk({tag, ".f_data"},    f_rd_data, 32'h0);
    chk({tag, ".l_data"},    l_rd_data, 32'h0);
    chk({tag, ".acks"},      {30'h0, f_rd_ack, l_rd_ack}, 32'h0);
    chk({tag, ".errs"},      {30'h0, f_rd_err, l_rd_err}, 32'h0);
    chk({tag, ".busy"},      {31'h0, busy}, 32'h0);
    chk({tag, ".grant_l"},   {31'h0, grant_l}, 32'h0);
  endtask

  initial begin : stim
    logic exp_l;
    logic prev_acked_l;
    reset_n         = 1'b0;
    f_rd_addr       = 32'h0;
    f_rd_addr_valid = 1'b0;
    l_rd_addr       = 32'h0;
    l_rd_addr_valid = 1'b0;
    mem_rd_data     = 32'h0;
    mem_rd_ack      = 1'b0;

    // ---- reset state
    tick; tick;
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick;
    chk("post_reset.busy", {31'h0, busy}, 32'h0);

    // ---- single fetch with address change during WAIT
    f_rd_addr = 32'h100; f_rd_addr_valid = 1'b1;
    tick;                                   // first WAIT cycle
    chk("fetch.mem_valid", {31'h0, mem_rd_addr_valid}, 32'h1);
    chk("fetch.mem_addr", mem_rd_addr, 32'h100);
    chk("fetch.grant_l", {31'h0, grant_l}, 32'h0);
    chk("fetch.busy", {31'h0, busy}, 32'h1);
    f_rd_addr = 32'h200;
    tick;                                   // second WAIT cycle
    chk("stable.mem_addr", mem_rd_addr, 32'h100);
    chk("fetch.no_early_ack", {31'h0, f_rd_ack}, 32'h0);
    mem_rd_ack = 1'b1; mem_rd_data = 32'hDEADBEEF;
    tick;                                   // RESP
    chk("fetch.f_ack", {31'h0, f_rd_ack}, 32'h1);
    chk("fetch.f_data", f_rd_data, 32'hDEADBEEF);
    chk("fetch.f_err", {31'h0, f_rd_err}, 32'h0);
    chk("fetch.l_ack", {31'h0, l_rd_ack}, 32'h0);
    chk("fetch.mem_valid_drop", {31'h0, mem_rd_addr_valid}, 32'h0);
    chk("fetch.mem_addr_hold", mem_rd_addr, 32'h100);
    f_rd_addr_valid = 1'b0; mem_rd_ack = 1'b0;
    tick;                                   // IDLE
    chk("fetch.ack_one_cycle", {31'h0, f_rd_ack}, 32'h0);
    chk("fetch.f_data_hold", f_rd_data, 32'hDEADBEEF);
    chk("fetch.busy_idle", {31'h0, busy}, 32'h0);

    // ---- simultaneous requests out of reset
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    f_rd_addr = 32'h10; f_rd_addr_valid = 1'b1;
    l_rd_addr = 32'h20; l_rd_addr_valid = 1'b1;
    mem_rd_ack = 1'b1; mem_rd_data = 32'h11111111;
    tick;                                   // WAIT for F
    chk("tie.first_grant_l", {31'h0, grant_l}, 32'h0);
    chk("tie.first_addr", mem_rd_addr, 32'h10);
    chk("tie.first_valid", {31'h0, mem_rd_addr_valid}, 32'h1);
    tick;                                   // RESP F
    chk("tie.f_ack", {31'h0, f_rd_ack}, 32'h1);
    chk("tie.f_data", f_rd_data, 32'h11111111);
    chk("tie.l_ack_low", {31'h0, l_rd_ack}, 32'h0);
    f_rd_addr_valid = 1'b0;
    tick;                                   // IDLE
    chk("tie.gap_valid", {31'h0, mem_rd_addr_valid}, 32'h0);
    mem_rd_data = 32'h22222222;
    tick;                                   // WAIT for L, 3 cycles after first
    chk("tie.second_valid", {31'h0, mem_rd_addr_valid}, 32'h1);
    chk("tie.second_grant_l", {31'h0, grant_l}, 32'h1);
    chk("tie.second_addr", mem_rd_addr, 32'h20);
    tick;                                   // RESP L
    chk("tie.l_ack", {31'h0, l_rd_ack}, 32'h1);
    chk("tie.l_data", l_rd_data, 32'h22222222);
    chk("tie.f_ack_low", {31'h0, f_rd_ack}, 32'h0);
    chk("tie.f_data_hold", f_rd_data, 32'h11111111);
    l_rd_addr_valid = 1'b0;
    tick;                                   // IDLE

    // ---- sustained contention: last grant was L, so F goes first
    f_rd_addr = 32'h1000; l_rd_addr = 32'h2000;
    f_rd_addr_valid = 1'b1; l_rd_addr_valid = 1'b1;
    prev_acked_l = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_l = i[0];
      tick;                                 // WAIT
      chk($sformatf("rr%0d.grant_l", i), {31'h0, grant_l}, {31'h0, exp_l});
      chk($sformatf("rr%0d.addr", i), mem_rd_addr, exp_l ? 32'h2000 : 32'h1000);
      mem_rd_data = 32'hA0000000 + i;
      tick;                                 // RESP
      chk($sformatf("rr%0d.acks", i), {30'h0, f_rd_ack, l_rd_ack},
          exp_l ? 32'h1 : 32'h2);
      chk($sformatf("rr%0d.data", i), exp_l ? l_rd_data : f_rd_data, 32'hA0000000 + i);
      chk($sformatf("rr%0d.no_repeat", i), {31'h0, l_rd_ack}, {31'h0, ~prev_acked_l});
      prev_acked_l = l_rd_ack;
      tick;                                 // IDLE
      chk($sformatf("rr%0d.idle_acks", i), {30'h0, f_rd_ack, l_rd_ack}, 32'h0);
    end
    f_rd_addr_valid = 1'b0; l_rd_addr_valid = 1'b0; mem_rd_ack = 1'b0;
    tick;                                   // stays IDLE
    chk("rr.drained_busy", {31'h0, busy}, 32'h0);

    // ---- timeout: L requests, memory never acks
    l_rd_addr = 32'h40; l_rd_addr_valid = 1'b1;
    tick;                                   // valid rises (V)
    chk("to.valid", {31'h0, mem_rd_addr_valid}, 32'h1);
    chk("to.addr", mem_rd_addr, 32'h40);
    chk("to.grant_l", {31'h0, grant_l}, 32'h1);
    for (int k = 1; k <= 4; k++) begin
      tick;                                 // V+1 .. V+4 still waiting
      chk($sformatf("to.wait%0d.valid", k), {31'h0, mem_rd_addr_valid}, 32'h1);
      chk($sformatf("to.wait%0d.ack", k), {31'h0, l_rd_ack}, 32'h0);
    end
    tick;                                   // V+5: abort
    chk("to.l_ack", {31'h0, l_rd_ack}, 32'h1);
    chk("to.l_err", {31'h0, l_rd_err}, 32'h1);
    chk("to.l_data", l_rd_data, 32'h0);
    chk("to.valid_drop", {31'h0, mem_rd_addr_valid}, 32'h0);
    chk("to.f_ack", {31'h0, f_rd_ack}, 32'h0);
    l_rd_addr_valid = 1'b0;
    mem_rd_ack = 1'b1; mem_rd_data = 32'h55555555;   // late ack
    tick;                                   // IDLE
    chk("late.acks", {30'h0, f_rd_ack, l_rd_ack}, 32'h0);
    chk("late.errs", {30'h0, f_rd_err, l_rd_err}, 32'h0);
    tick;
    chk("late.acks2", {30'h0, f_rd_ack, l_rd_ack}, 32'h0);
    chk("late.l_data", l_rd_data, 32'h0);
    chk("late.busy", {31'h0, busy}, 32'h0);
    chk("late.valid", {31'h0, mem_rd_addr_valid}, 32'h0);
    mem_rd_ack = 1'b0;

    // ---- reset mid-WAIT: last grant was L, so make F win first, then reset
    f_rd_addr = 32'h300; f_rd_addr_valid = 1'b1;
    tick;                                   // WAIT
    chk("rst.wait_valid", {31'h0, mem_rd_addr_valid}, 32'h1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("rst.async");
    l_rd_addr = 32'h400; l_rd_addr_valid = 1'b1;
    tick;
    chk("rst.held_acks", {30'h0, f_rd_ack, l_rd_ack}, 32'h0);
    reset_n = 1'b1;
    tick;                                   // tie after release -> F
    chk("rst.tie_grant_l", {31'h0, grant_l}, 32'h0);
    chk("rst.tie_addr", mem_rd_addr, 32'h300);
    chk("rst.no_ack", {30'h0, f_rd_ack, l_rd_ack}, 32'h0);
    mem_rd_ack = 1'b1; mem_rd_data = 32'h77777777;
    tick;                                   // RESP F
    chk("rst.f_ack", {31'h0, f_rd_ack}, 32'h1);
    chk("rst.f_data", f_rd_data, 32'h77777777);
    f_rd_addr_valid = 1'b0; l_rd_addr_valid = 1'b0; mem_rd_ack = 1'b0;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_rd_arbiter.md
# mem_rd_arbiter

Shares the single instruction/data memory read port between two requesters: instruction fetch (port F) and load unit (port L). It sits between the instruction handler / load path and memory. It serialises requests with round-robin arbitration and forwards exactly one transaction at a time. It returns data and a one-cycle ack to the winning requester, and aborts with an error if memory fails to ack within a bounded time.

## Interface
- TIMEOUT_CYCLES, default 64: maximum number of WAIT cycles without `mem_rd_ack` before an abort; 0 disables the timeout.
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- f_rd_addr  in  32  fetch address.
- f_rd_addr_valid  in  1  fetch request; held with a stable address until `f_rd_ack`.
- f_rd_data  out  32  fetch read data; valid while `f_rd_ack` is high.
- f_rd_ack  out  1  one-cycle completion pulse to fetch.
- f_rd_err  out  1  high with `f_rd_ack` if the transaction timed out.
- l_rd_addr, l_rd_addr_valid, l_rd_data, l_rd_ack, l_rd_err: identical to the fetch port, for the load unit.
- mem_rd_addr  out  32  address to memory.
- mem_rd_addr_valid  out  1  request to memory; held until `mem_rd_ack` or timeout.
- mem_rd_data  in  32  memory read data; sampled when `mem_rd_ack` is high.
- mem_rd_ack  in  1  memory completion; level, sampled only in WAIT.
- busy  out  1  high in WAIT and RESP.
- grant_l  out  1  owner of the current or last transaction (0 = F, 1 = L).

## Operation
- State machine: IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any `*_valid` is high, pick a winner:
    - If only one requester is valid, it wins.
    - If both are valid, the requester opposite to `last_grant` wins.
  - Register the winner's address into `mem_rd_addr`, set `mem_rd_addr_valid` = 1, update `last_grant` and `grant_l`, clear the timeout counter, go to WAIT.
  - If neither is valid, stay in IDLE.
- WAIT:
  - On `mem_rd_ack` = 1:
    - Latch `mem_rd_data` into the winner's data output and pulse the winner's ack.
    - Set err = 0, `mem_rd_addr_valid` = 0, go to RESP.
  - Otherwise, increment the counter. When the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES is not 0):
    - `mem_rd_addr_valid` = 0.
    - Winner's data = 0, ack = 1, err = 1.
    - Go to RESP.
- RESP: all acks and errs return to 0; go to IDLE. Data outputs hold their last value.
- The loser's valid stays pending and is served in the next IDLE cycle. This guarantees no starvation: service alternates whenever both requesters are valid.
- Requesters drop valid in the cycle after their ack. The arbiter samples valids only in IDLE, so no duplicate service occurs.
- A `mem_rd_ack` arriving in IDLE or RESP (late ack after a timeout, or a spurious ack) is ignored.
- Address changes on a requester while its request is in flight are ignored; the address is captured at grant.
- The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates; it never wraps.

## Timing
- Reset (asynchronous, immediate on `reset_n` = 0):
  - State IDLE, `last_grant` = L, so F wins the first tie.
  - All outputs 0: `mem_rd_addr`, `mem_rd_addr_valid`, both data outputs, acks, errs, `busy`, `grant_l`.
  - Reset mid-transaction abandons the transaction; no ack is issued.
  - Release is synchronous to the next clk edge.
- Grant latency: a valid seen in IDLE at cycle N gives `mem_rd_addr_valid` = 1 from cycle N+1.
- Response latency: `mem_rd_ack` seen at cycle M gives the requester ack, with data, at cycle M+1. `mem_rd_addr_valid` is 0 from M+1.
- Minimum transaction is 3 cycles (IDLE, WAIT, RESP), with memory acking in the first WAIT cycle.
- Back-to-back throughput is one transaction per 3 cycles.
- Timeout: with no ack, the abort ack and err appear TIMEOUT_CYCLES+1 cycles after `mem_rd_addr_valid` rises.
- Acks are exactly one cycle wide. At most one of `f_rd_ack` / `l_rd_ack` is high in any cycle.

## Test plan
- Single fetch: F requests 0x100; memory acks 2 cycles later with 0xDEADBEEF.
  - `mem_rd_addr` = 0x100 at N+1.
  - `f_rd_ack` = 1 and `f_rd_data` = 0xDEADBEEF for exactly one cycle.
  - `l_rd_ack` stays 0.
- Simultaneous requests out of reset: F = 0x10, L = 0x20, memory acks immediately each time.
  - F is served first, then L.
  - Grants go F, L; the second `mem_rd_addr_valid` rises 3 cycles after the first.
- Sustained contention: both ports re-request immediately after every ack, for 10 transactions.
  - `grant_l` alternates 0,1,0,1,…
  - No port is acked twice in a row.
- Timeout with TIMEOUT_CYCLES = 4: L requests 0x40 and memory never acks.
  - `mem_rd_addr_valid` drops, and `l_rd_ack` = 1 with `l_rd_err` = 1 and `l_rd_data` = 0, 5 cycles after the request issue.
  - A late `mem_rd_ack` during the next IDLE is ignored.
- Reset mid-WAIT: assert `reset_n` = 0 during WAIT.
  - All outputs are 0 immediately, with no ack.
  - After release, F is granted first on a tie.
- Address stability: change `f_rd_addr` from 0x100 to 0x200 during WAIT.
  - `mem_rd_addr` stays 0x100 until the transaction completes.
